// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode slice: widths, reset PC, bubble word and IF/ID state.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LIVE  = 2'd1,
    HELD  = 2'd2
  } fetchState_t;

  function automatic logic isMisaligned(input logic [1:0] pcLo);
    return pcLo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: EMPTY/LIVE/HELD tracking plus the stall hold word.
// Optional misaligned-fetch flag under FETCH_MISALIGN_CHECK_EN.
module if_id_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stallD,
  input  logic            flushD,
  input  logic [31:0]     imem_rdata,
  input  logic [XLEN-1:0] pcF,
  input  logic [XLEN-1:0] pcPlus4F,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD,
  output logic            misalignD
);
  import riscv_pkg::*;

  fetchState_t state;
  logic [31:0] holdQ;
  logic        load;

  assign load = !flushD && !stallD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      holdQ     <= '0;
      pcD       <= '0;
      pc_plus4D <= '0;
    end else begin
      unique case (state)
        EMPTY: state <= load ? LIVE : EMPTY;
        LIVE: begin
          if (flushD) state <= EMPTY;
          else if (stallD) begin
            // ROM output is untrusted while the PC is frozen, so keep the word now.
            state <= HELD;
            holdQ <= imem_rdata;
          end else state <= LIVE;
        end
        HELD: begin
          if (flushD)      state <= EMPTY;
          else if (stallD) state <= HELD;
          else             state <= LIVE;
        end
        default: state <= EMPTY;
      endcase
      if (load) begin
        pcD       <= pcF;
        pc_plus4D <= pcPlus4F;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flushD) misalignD <= 1'b0;
    else if (load)        misalignD <= isMisaligned(pcF[1:0]);
  end
`else
  assign misalignD = 1'b0;
`endif

  always_comb begin
    instrD = NOP_INSTR;
    unique case (state)
      LIVE:    instrD = imem_rdata;
      HELD:    instrD = holdQ;
      default: instrD = NOP_INSTR;
    endcase
  end

  assign validD = (state == LIVE) || (state == HELD);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux and the IF/ID register feeding decode.
// Define FETCH_MISALIGN_CHECK_EN to build the misaligned-fetch flag.
module fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            pc_srcE,
  input  logic [XLEN-1:0] pc_targetE,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD,
  output logic            misalignD
);

  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcPlus4F;

  assign pcPlus4F  = pcF + XLEN'(4);
  assign imem_addr = pcF;

  // Redirect beats stall: a resolved branch must not be lost behind a hazard.
  always_ff @(posedge clk) begin
    if (!rst_n)       pcF <= RESET_PC;
    else if (pc_srcE) pcF <= pc_targetE;
    else if (!stallF) pcF <= pcPlus4F;
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) uIfId (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallD     (stallD),
    .flushD     (flushD),
    .imem_rdata (imem_rdata),
    .pcF        (pcF),
    .pcPlus4F   (pcPlus4F),
    .instrD     (instrD),
    .pcD        (pcD),
    .pc_plus4D  (pc_plus4D),
    .validD     (validD),
    .misalignD  (misalignD)
  );

endmodule
